// File: rtl/jtdd_prom_we_if.sv
// Loader-side and SDRAM-side signals of the download sequencer.
// The slave modport is the sequencer itself. The master modport is whoever
// drives the loader byte stream and acknowledges the SDRAM writes.
interface jtdd_prom_we_if;
  logic        downloading;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_rdy;
  logic        prom_we;
  logic        dwnld_done;
  logic        ovf;

  modport slave (
    input  downloading,
    input  ioctl_addr,
    input  ioctl_dout,
    input  ioctl_wr,
    input  prog_rdy,
    output prog_addr,
    output prog_data,
    output prog_mask,
    output prog_we,
    output prom_we,
    output dwnld_done,
    output ovf
  );

  modport master (
    output downloading,
    output ioctl_addr,
    output ioctl_dout,
    output ioctl_wr,
    output prog_rdy,
    input  prog_addr,
    input  prog_data,
    input  prog_mask,
    input  prog_we,
    input  prom_we,
    input  dwnld_done,
    input  ovf
  );
endinterface

// File: rtl/jtdd_prom_we.sv
// Download-time address decoder and SDRAM write sequencer.
// Turns the loader byte stream into SDRAM byte-lane writes for the ROM regions
// and into single-cycle write strobes for the priority PROM. A one-byte buffer
// absorbs a byte that arrives while an SDRAM write is still waiting for its
// acknowledge.
module jtdd_prom_we #(
  parameter logic [21:0] SND_START   = 22'h04_0000,
  parameter logic [21:0] ADPCM_START = 22'h04_8000,
  parameter logic [21:0] CHAR_START  = 22'h06_8000,
  parameter logic [21:0] SCR_START   = 22'h07_8000,
  parameter logic [21:0] OBJ_START   = 22'h0F_8000,
  parameter logic [21:0] MCU_START   = 22'h1F_8000,
  parameter logic [21:0] PROM_START  = 22'h1F_C000,
  parameter logic [21:0] ROM_END     = 22'h1F_C100
) (
  input  logic         clk,
  input  logic         rst_n,
  jtdd_prom_we_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RELOAD
  } state_e;

  typedef enum logic [3:0] {
    RG_MAIN,
    RG_SND,
    RG_ADPCM,
    RG_CHAR,
    RG_SCR,
    RG_OBJ,
    RG_MCU,
    RG_PROM,
    RG_NONE
  } region_e;

  // Decode results
  region_e     region;
  logic [21:0] regionBase;
  logic [21:0] regionOffset;
  logic [21:0] offsetRot;
  logic [21:0] byteAddr;
  logic [21:0] wordAddr;
  logic [1:0]  byteMask;
  logic [15:0] wordData;
  logic        isGfx;
  logic        sdWr;
  logic        promWr;

  // Sequencer state
  state_e      state_q,     state_d;
  logic [21:0] sdAddr_q,    sdAddr_d;
  logic [15:0] sdData_q,    sdData_d;
  logic [1:0]  sdMask_q,    sdMask_d;
  logic        progWe_q,    progWe_d;

  // Pending byte buffer
  logic        bufValid_q,  bufValid_d;
  logic [21:0] bufAddr_q,   bufAddr_d;
  logic [15:0] bufData_q,   bufData_d;
  logic [1:0]  bufMask_q,   bufMask_d;

  // PROM strobe
  logic        promWe_q,    promWe_d;
  logic [7:0]  promAddr_q,  promAddr_d;
  logic [3:0]  promData_q,  promData_d;

  // Status
  logic        ovf_q,       ovf_d;
  logic        dlPrev_q,    dlPrev_d;
  logic        doneArm_q,   doneArm_d;
  logic        done_q,      done_d;

  // Find which ROM region the incoming byte belongs to and where it starts
  always_comb begin
    region     = RG_NONE;
    regionBase = '0;
    if (bus.ioctl_addr < SND_START) begin
      region     = RG_MAIN;
      regionBase = '0;
    end else if (bus.ioctl_addr < ADPCM_START) begin
      region     = RG_SND;
      regionBase = SND_START;
    end else if (bus.ioctl_addr < CHAR_START) begin
      region     = RG_ADPCM;
      regionBase = ADPCM_START;
    end else if (bus.ioctl_addr < SCR_START) begin
      region     = RG_CHAR;
      regionBase = CHAR_START;
    end else if (bus.ioctl_addr < OBJ_START) begin
      region     = RG_SCR;
      regionBase = SCR_START;
    end else if (bus.ioctl_addr < MCU_START) begin
      region     = RG_OBJ;
      regionBase = OBJ_START;
    end else if (bus.ioctl_addr < PROM_START) begin
      region     = RG_MCU;
      regionBase = MCU_START;
    end else if (bus.ioctl_addr < ROM_END) begin
      region     = RG_PROM;
      regionBase = PROM_START;
    end
  end

  // Graphics regions move offset bit 4 to the LSB so the two plane bytes that
  // sit 16 bytes apart in the file land in the same 16-bit SDRAM word
  always_comb begin
    regionOffset = bus.ioctl_addr - regionBase;
    isGfx        = (region == RG_CHAR) || (region == RG_SCR) || (region == RG_OBJ);
    offsetRot    = isGfx ? {regionOffset[21:5], regionOffset[3:0], regionOffset[4]}
                         : regionOffset;
    byteAddr     = regionBase + offsetRot;
    wordAddr     = byteAddr >> 1;
    byteMask     = offsetRot[0] ? 2'b01 : 2'b10;
    wordData     = {bus.ioctl_dout, bus.ioctl_dout};
    sdWr         = bus.ioctl_wr && bus.downloading &&
                   (region != RG_NONE) && (region != RG_PROM);
    promWr       = bus.ioctl_wr && bus.downloading && (region == RG_PROM);
  end

  // Next-state logic: SDRAM write FSM, byte buffer, PROM strobe, done pulse
  always_comb begin
    state_d    = state_q;
    sdAddr_d   = sdAddr_q;
    sdData_d   = sdData_q;
    sdMask_d   = sdMask_q;
    progWe_d   = progWe_q;
    bufValid_d = bufValid_q;
    bufAddr_d  = bufAddr_q;
    bufData_d  = bufData_q;
    bufMask_d  = bufMask_q;
    promWe_d   = 1'b0;
    promAddr_d = promAddr_q;
    promData_d = promData_q;
    ovf_d      = ovf_q;
    dlPrev_d   = bus.downloading;
    doneArm_d  = doneArm_q;
    done_d     = 1'b0;

    // PROM bytes bypass the SDRAM path entirely, whatever the FSM is doing
    if (promWr) begin
      promWe_d   = 1'b1;
      promAddr_d = regionOffset[7:0];
      promData_d = bus.ioctl_dout[3:0];
    end

    case (state_q)
      ST_IDLE: begin
        progWe_d = 1'b0;
        if (sdWr) begin
          sdAddr_d = wordAddr;
          sdData_d = wordData;
          sdMask_d = byteMask;
          progWe_d = 1'b1;
          state_d  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        progWe_d = 1'b1;
        if (sdWr) begin
          if (!bufValid_q) begin
            bufValid_d = 1'b1;
            bufAddr_d  = wordAddr;
            bufData_d  = wordData;
            bufMask_d  = byteMask;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (bus.prog_rdy) begin
          progWe_d = 1'b0;
          state_d  = (bufValid_q || sdWr) ? ST_RELOAD : ST_IDLE;
        end
      end

      ST_RELOAD: begin
        // The buffered byte moves to the outputs, which frees the slot for a
        // byte arriving on this very cycle
        sdAddr_d   = bufAddr_q;
        sdData_d   = bufData_q;
        sdMask_d   = bufMask_q;
        progWe_d   = 1'b1;
        bufValid_d = 1'b0;
        state_d    = ST_WAIT;
        if (sdWr) begin
          bufValid_d = 1'b1;
          bufAddr_d  = wordAddr;
          bufData_d  = wordData;
          bufMask_d  = byteMask;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        progWe_d = 1'b0;
      end
    endcase

    // The end of download is reported only once every pending write drained
    if (bus.downloading) begin
      doneArm_d = 1'b0;
    end else if (dlPrev_q) begin
      doneArm_d = 1'b1;
    end
    if (doneArm_q && !bus.downloading && (state_q == ST_IDLE) && !bufValid_q) begin
      done_d    = 1'b1;
      doneArm_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sdAddr_q   <= '0;
      sdData_q   <= '0;
      sdMask_q   <= 2'b11;
      progWe_q   <= 1'b0;
      bufValid_q <= 1'b0;
      bufAddr_q  <= '0;
      bufData_q  <= '0;
      bufMask_q  <= 2'b11;
      promWe_q   <= 1'b0;
      promAddr_q <= '0;
      promData_q <= '0;
      ovf_q      <= 1'b0;
      dlPrev_q   <= 1'b0;
      doneArm_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sdAddr_q   <= sdAddr_d;
      sdData_q   <= sdData_d;
      sdMask_q   <= sdMask_d;
      progWe_q   <= progWe_d;
      bufValid_q <= bufValid_d;
      bufAddr_q  <= bufAddr_d;
      bufData_q  <= bufData_d;
      bufMask_q  <= bufMask_d;
      promWe_q   <= promWe_d;
      promAddr_q <= promAddr_d;
      promData_q <= promData_d;
      ovf_q      <= ovf_d;
      dlPrev_q   <= dlPrev_d;
      doneArm_q  <= doneArm_d;
      done_q     <= done_d;
    end
  end

  // prog_addr/prog_data are shared: during the one-cycle PROM strobe they carry
  // the PROM index and nibble, otherwise the held SDRAM request. prog_we stays
  // asserted throughout, since SDRAM latches the address on the request edge.
  assign bus.prog_addr  = promWe_q ? {14'd0, promAddr_q} : sdAddr_q;
  assign bus.prog_data  = promWe_q ? {12'd0, promData_q} : sdData_q;
  assign bus.prog_mask  = sdMask_q;
  assign bus.prog_we    = progWe_q;
  assign bus.prom_we    = promWe_q;
  assign bus.dwnld_done = done_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_jtdd_prom_we.sv
// Testbench for the download decoder / SDRAM write sequencer.
// Expected SDRAM writes and PROM strobes are queued as bytes are sent and
// compared by a monitor as the DUT produces them.
module tb_jtdd_prom_we;

  logic clk = 1'b0;
  logic rst_n;

  jtdd_prom_we_if ifc();

  jtdd_prom_we dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } sdExp_t;

  typedef struct {
    logic [7:0] idx;
    logic [3:0] nib;
  } promExp_t;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  dout;
    int          kind;
    logic [21:0] expAddr;
    logic [15:0] expData;
    logic [1:0]  expMask;
    logic [7:0]  expIdx;
    logic [3:0]  expNib;
  } vec_t;

  localparam int KIND_SD   = 0;
  localparam int KIND_PROM = 1;
  localparam int KIND_NONE = 2;
  localparam int NUM_VECS  = 13;

  sdExp_t   sdQ[$];
  promExp_t promQ[$];
  vec_t     vecs[NUM_VECS];

  int total      = 0;
  int bad        = 0;
  int sdBursts   = 0;
  int promPulses = 0;
  int ackDelay   = 3;
  bit ackEnable  = 1'b1;
  logic prevWe   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send one byte; called at a negedge, returns at the next negedge with
  // ioctl_wr low so back-to-back calls give consecutive strobes
  task automatic applyStimulus(input logic [21:0] addr, input logic [7:0] dout);
    ifc.ioctl_addr = addr;
    ifc.ioctl_dout = dout;
    ifc.ioctl_wr   = 1'b1;
    @(negedge clk);
    ifc.ioctl_wr   = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((sdQ.size() != 0 || promQ.size() != 0 || ifc.prog_we) && n < 80) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput({name, "_timeout"}, 32'(n >= 80), 32'd0);
  endtask

  // SDRAM responder: acknowledges each request after ackDelay cycles
  initial begin
    int cnt;
    cnt = 0;
    ifc.prog_rdy = 1'b0;
    forever begin
      @(negedge clk);
      ifc.prog_rdy = 1'b0;
      if (ifc.prog_we && ackEnable && rst_n) begin
        cnt++;
        if (cnt >= ackDelay) begin
          ifc.prog_rdy = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: every new SDRAM request and every PROM strobe is matched
  // against the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.prog_we && !prevWe) begin
        sdBursts++;
        if (sdQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_prog_we: got addr %0h data %0h with no write expected",
                   ifc.prog_addr, ifc.prog_data);
        end else begin
          sdExp_t e;
          e = sdQ.pop_front();
          checkOutput("sd_addr", 32'(ifc.prog_addr), 32'(e.addr));
          checkOutput("sd_data", 32'(ifc.prog_data), 32'(e.data));
          checkOutput("sd_mask", 32'(ifc.prog_mask), 32'(e.mask));
        end
      end
      if (ifc.prom_we) begin
        promPulses++;
        if (promQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_prom_we: got idx %0h with no strobe expected",
                   ifc.prog_addr[7:0]);
        end else begin
          promExp_t p;
          p = promQ.pop_front();
          checkOutput("prom_idx", 32'(ifc.prog_addr[7:0]), 32'(p.idx));
          checkOutput("prom_nib", 32'(ifc.prog_data[3:0]), 32'(p.nib));
        end
      end
    end
    prevWe = ifc.prog_we;
  end

  // Global time limit so the bench always reaches its summary line
  initial begin
    #400000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: got no end of test, required end before time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Main test sequence
  initial begin
    int b0;
    int p0;
    int cyc;
    int fallCyc;
    int doneCyc;
    int pulses;

    vecs[0]  = '{22'h000000, 8'h3C, KIND_SD,   22'h000000, 16'h3C3C, 2'b10, 8'h00, 4'h0};
    vecs[1]  = '{22'h000001, 8'h5A, KIND_SD,   22'h000000, 16'h5A5A, 2'b01, 8'h00, 4'h0};
    vecs[2]  = '{22'h068010, 8'h11, KIND_SD,   22'h034000, 16'h1111, 2'b01, 8'h00, 4'h0};
    vecs[3]  = '{22'h068000, 8'h22, KIND_SD,   22'h034000, 16'h2222, 2'b10, 8'h00, 4'h0};
    vecs[4]  = '{22'h040003, 8'h33, KIND_SD,   22'h020001, 16'h3333, 2'b01, 8'h00, 4'h0};
    vecs[5]  = '{22'h048000, 8'h44, KIND_SD,   22'h024000, 16'h4444, 2'b10, 8'h00, 4'h0};
    vecs[6]  = '{22'h078011, 8'h55, KIND_SD,   22'h03C001, 16'h5555, 2'b01, 8'h00, 4'h0};
    vecs[7]  = '{22'h0F8025, 8'h66, KIND_SD,   22'h07C015, 16'h6666, 2'b10, 8'h00, 4'h0};
    vecs[8]  = '{22'h1F8007, 8'h77, KIND_SD,   22'h0FC003, 16'h7777, 2'b01, 8'h00, 4'h0};
    vecs[9]  = '{22'h1FC005, 8'hA7, KIND_PROM, 22'h000000, 16'h0000, 2'b00, 8'h05, 4'h7};
    vecs[10] = '{22'h1FC0FF, 8'h3C, KIND_PROM, 22'h000000, 16'h0000, 2'b00, 8'hFF, 4'hC};
    vecs[11] = '{22'h1FC100, 8'h99, KIND_NONE, 22'h000000, 16'h0000, 2'b00, 8'h00, 4'h0};
    vecs[12] = '{22'h03FFFF, 8'hEE, KIND_SD,   22'h01FFFF, 16'hEEEE, 2'b01, 8'h00, 4'h0};

    rst_n           = 1'b0;
    ifc.downloading = 1'b1;
    ifc.ioctl_addr  = '0;
    ifc.ioctl_dout  = '0;
    ifc.ioctl_wr    = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_prog_we",    32'(ifc.prog_we),    32'd0);
    checkOutput("rst_prom_we",    32'(ifc.prom_we),    32'd0);
    checkOutput("rst_dwnld_done", 32'(ifc.dwnld_done), 32'd0);
    checkOutput("rst_ovf",        32'(ifc.ovf),        32'd0);
    checkOutput("rst_prog_addr",  32'(ifc.prog_addr),  32'd0);
    checkOutput("rst_prog_data",  32'(ifc.prog_data),  32'd0);
    checkOutput("rst_prog_mask",  32'(ifc.prog_mask),  32'h3);

    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single-byte region vectors");
    ackDelay = 3;
    for (int i = 0; i < NUM_VECS; i++) begin
      b0 = sdBursts;
      p0 = promPulses;
      if (vecs[i].kind == KIND_SD)
        sdQ.push_back('{vecs[i].expAddr, vecs[i].expData, vecs[i].expMask});
      else if (vecs[i].kind == KIND_PROM)
        promQ.push_back('{vecs[i].expIdx, vecs[i].expNib});
      applyStimulus(vecs[i].addr, vecs[i].dout);
      waitIdle($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_bursts", i), 32'(sdBursts - b0),
                  (vecs[i].kind == KIND_SD) ? 32'd1 : 32'd0);
      checkOutput($sformatf("vec%0d_prom_pulses", i), 32'(promPulses - p0),
                  (vecs[i].kind == KIND_PROM) ? 32'd1 : 32'd0);
    end
    checkOutput("ovf_after_vectors", 32'(ifc.ovf), 32'd0);

    $display("[TB] back-to-back bytes with slow acknowledge");
    ackDelay = 10;
    b0 = sdBursts;
    sdQ.push_back('{22'h000080, 16'h0101, 2'b10});
    sdQ.push_back('{22'h000080, 16'h0202, 2'b01});
    applyStimulus(22'h000100, 8'h01);
    applyStimulus(22'h000101, 8'h02);
    applyStimulus(22'h000102, 8'h03);
    waitIdle("b2b");
    checkOutput("b2b_bursts", 32'(sdBursts - b0), 32'd2);
    checkOutput("b2b_ovf",    32'(ifc.ovf),       32'd1);

    $display("[TB] PROM write while an SDRAM write is pending");
    ackDelay = 6;
    b0 = sdBursts;
    p0 = promPulses;
    sdQ.push_back('{22'h000090, 16'h1212, 2'b10});
    promQ.push_back('{8'h42, 4'h9});
    applyStimulus(22'h000120, 8'h12);
    applyStimulus(22'h1FC042, 8'hB9);
    waitIdle("prom_in_wait");
    checkOutput("prom_in_wait_bursts", 32'(sdBursts - b0),   32'd1);
    checkOutput("prom_in_wait_pulses", 32'(promPulses - p0), 32'd1);

    $display("[TB] end of download with a write pending");
    ackDelay = 4;
    sdQ.push_back('{22'h000100, 16'h1111, 2'b10});
    applyStimulus(22'h000200, 8'h11);
    ifc.downloading = 1'b0;
    cyc = 0;
    fallCyc = -1;
    doneCyc = -1;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      cyc++;
      if (!ifc.prog_we && fallCyc < 0) fallCyc = cyc;
      if (ifc.dwnld_done) begin
        pulses++;
        if (doneCyc < 0) doneCyc = cyc;
      end
    end
    checkOutput("done_pulses",  32'(pulses),  32'd1);
    checkOutput("done_latency", 32'(doneCyc), 32'(fallCyc + 1));
    checkOutput("done_drained", 32'(sdQ.size()), 32'd0);
    ifc.downloading = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] download resumes before the done pulse");
    ackDelay = 8;
    sdQ.push_back('{22'h000180, 16'h2222, 2'b10});
    applyStimulus(22'h000300, 8'h22);
    ifc.downloading = 1'b0;
    @(negedge clk);
    ifc.downloading = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (ifc.dwnld_done) pulses++;
    end
    checkOutput("cancel_pulses",  32'(pulses),     32'd0);
    checkOutput("cancel_drained", 32'(sdQ.size()), 32'd0);

    $display("[TB] strobe with downloading low is ignored");
    ifc.downloading = 1'b0;
    b0 = sdBursts;
    applyStimulus(22'h000400, 8'h33);
    repeat (5) @(negedge clk);
    checkOutput("not_dl_bursts", 32'(sdBursts - b0), 32'd0);
    ifc.downloading = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] reset during a pending write with a full buffer");
    ackEnable = 1'b0;
    sdQ.push_back('{22'h0000A0, 16'h4444, 2'b10});
    applyStimulus(22'h000140, 8'h44);
    applyStimulus(22'h000141, 8'h55);
    @(negedge clk);
    checkOutput("pre_rst_prog_we", 32'(ifc.prog_we), 32'd1);
    checkOutput("pre_rst_ovf",     32'(ifc.ovf),     32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_prog_we", 32'(ifc.prog_we),   32'd0);
    checkOutput("mid_rst_ovf",     32'(ifc.ovf),       32'd0);
    checkOutput("mid_rst_mask",    32'(ifc.prog_mask), 32'h3);
    rst_n = 1'b1;
    sdQ.delete();
    @(negedge clk);
    ackEnable = 1'b1;
    ackDelay = 2;
    b0 = sdBursts;
    sdQ.push_back('{22'h0000A8, 16'h6666, 2'b10});
    applyStimulus(22'h000150, 8'h66);
    waitIdle("post_rst");
    checkOutput("post_rst_bursts", 32'(sdBursts - b0), 32'd1);
    checkOutput("post_rst_ovf",    32'(ifc.ovf),       32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtdd_prom_we.md
Name: jtdd_prom_we

Overview:
- Download-time address decoder and SDRAM write sequencer, directly upstream of the game top level.
- Takes the byte stream from the loader (ioctl) and produces SDRAM word writes for the main, sound, ADPCM, char, scroll, object and MCU regions.
- Produces the priority-PROM write strobe (prom_we, prog_addr[7:0], prog_data[3:0]) that the video stage consumes.
- Buffers one pending byte so the loader never stalls on SDRAM latency.

Parameters:
- SND_START, 22'h04_0000: first byte offset of the sound CPU ROM.
- ADPCM_START, 22'h04_8000: first byte offset of the ADPCM ROMs (both channels, contiguous).
- CHAR_START, 22'h06_8000: first byte offset of the char ROM.
- SCR_START, 22'h07_8000: first byte offset of the scroll ROM.
- OBJ_START, 22'h0F_8000: first byte offset of the object ROM.
- MCU_START, 22'h1F_8000: first byte offset of the MCU ROM.
- PROM_START, 22'h1F_C000: first byte offset of the priority PROM (256 entries).
- ROM_END, 22'h1F_C100: first offset past the image; bytes at or above it are ignored.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: synchronous reset, active-low.
- downloading, in, 1: loader active.
- ioctl_addr, in, 22: byte offset of the incoming byte.
- ioctl_dout, in, 8: incoming byte.
- ioctl_wr, in, 1: one-cycle strobe, byte valid.
- prog_addr, out, 22: SDRAM word address, or PROM index in [7:0].
- prog_data, out, 16: byte replicated on both halves; [3:0] is PROM data.
- prog_mask, out, 2: active-low byte enable; 2'b10 writes the low byte, 2'b01 writes the high byte.
- prog_we, out, 1: SDRAM write request, held until acknowledged.
- prog_rdy, in, 1: SDRAM acknowledge, one cycle.
- prom_we, out, 1: one-cycle PROM write strobe.
- dwnld_done, out, 1: one-cycle pulse at the end of download.
- ovf, out, 1: sticky flag, a byte was dropped.

Behaviour:
- Reset (rst_n=0 at a clock edge): prog_we=0, prom_we=0, dwnld_done=0, ovf=0, prog_addr=0, prog_data=0, prog_mask=2'b11. State goes to IDLE and the pending buffer is emptied. Reset mid-write abandons the request with no acknowledge wait.
- Region decode (combinational on ioctl_addr; ranges are inclusive start, exclusive next start):
  - region offset = ioctl_addr minus the region start.
  - MAIN and SND use offset unchanged.
  - CHAR, SCR and OBJ rotate bit 4 to the LSB: off' = {off[21:5], off[3:0], off[4]}. This pairs plane bytes in one 16-bit word.
- SDRAM word address = ioctl_addr with the region offset term replaced by off' (equal for non-graphics regions), shifted right by 1.
- Byte select:
  - off'[0]=0: mask 2'b10.
  - off'[0]=1: mask 2'b01.
- States:
  - IDLE: on ioctl_wr in an SDRAM region (below PROM_START), register address, data and mask, assert prog_we, go to WAIT.
  - IDLE, PROM region: on ioctl_wr in [PROM_START, ROM_END), prom_we=1 on the next cycle, with prog_addr[7:0]=offset[7:0] and prog_data[3:0]=ioctl_dout[3:0]. No SDRAM access is made and the state stays IDLE.
  - WAIT: prog_we=1 and outputs stable. On prog_rdy, drop prog_we on the next cycle. If the buffer is full, load it and re-assert prog_we one cycle later; otherwise go to IDLE.
- Latency: prog_we rises 1 cycle after ioctl_wr; prom_we pulses 1 cycle after ioctl_wr.
- Buffer:
  - ioctl_wr during WAIT stores the byte in the single buffer slot.
  - ioctl_wr while the buffer is full drops the byte and sets ovf=1.
  - ovf is cleared only by reset.
  - ioctl_wr on the same cycle as prog_rdy goes to the buffer; it is consumed immediately after.
- PROM write during WAIT: it is issued immediately and does not use the buffer.
- Out-of-range bytes (>= ROM_END): ignored, no strobe.
- ioctl_wr with downloading=0: ignored.
- dwnld_done:
  - Arms on the falling edge of downloading.
  - Pulses once when the state is IDLE and the buffer is empty.
  - If downloading rises again before the pulse, the arm is cancelled.

Test Plan:
- Main bytes: write 0x00 to 0x3C at offset 0, then 0x5A at offset 1 with prog_rdy 3 cycles later. Expect prog_addr=0, mask 2'b10 then 2'b01, prog_data 16'h3C3C then 16'h5A5A, one prog_we burst per byte.
- Graphics rotation: write offset 0x10 into the char region (ioctl_addr 0x06_8010). Expect off'=0x01, prog_addr=(0x06_8000>>1)+0, mask 2'b01.
- PROM: write 0xA7 at 0x1F_C005. Expect a single-cycle prom_we with prog_addr[7:0]=0x05, prog_data[3:0]=0x7, and prog_we staying 0.
- Back-to-back with slow ack: three ioctl_wr on consecutive cycles, prog_rdy 10 cycles after each request. Expect the first two bytes written in order, the third dropped, and ovf=1.
- End of download: drop downloading while WAIT is pending. Expect dwnld_done one cycle after the final prog_we falls, exactly once.
- Reset mid-operation: assert rst_n=0 during WAIT with the buffer full. Expect prog_we=0 on the next cycle, ovf=0, and the next byte accepted normally.
